// File: rtl/wishbone_scratch_slave.sv
// Wishbone classic slave exposing NREGS read/write scratch registers; option macro WB_SCRATCH_RETRY_EN adds busy_i -> rty_o.
// Latency: ack_o/err_o/rty_o asserted (registered) WAIT_STATES+1 cycles after cyc_i&stb_i; one transfer per WAIT_STATES+2 cycles.
// Backpressure: the master holds cyc_i&stb_i until termination; dropping either during WAIT aborts with no write.
module wishbone_scratch_slave #(
    parameter int                    DATA_WIDTH      = 8,
    parameter int                    ADDR_WIDTH      = 16,
    parameter int                    NREGS           = 16,
    parameter int                    WAIT_STATES     = 0,
    parameter bit                    ERR_ON_UNMAPPED = 1'b1,
    parameter logic [DATA_WIDTH-1:0] FILL_VALUE      = 8'hFF
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        cyc_i,
    input  logic                        stb_i,
    input  logic                        wr_i,
    input  logic [ADDR_WIDTH-1:0]       adr_i,
    input  logic [DATA_WIDTH-1:0]       dat_i,
    output logic [DATA_WIDTH-1:0]       dat_o,
    output logic                        ack_o,
    output logic                        err_o,
    output logic                        rty_o,
`ifdef WB_SCRATCH_RETRY_EN
    input  logic                        busy_i,
`endif
    output logic [NREGS*DATA_WIDTH-1:0] regs_o
);

    localparam int                  IDX_W     = (NREGS > 1) ? $clog2(NREGS) : 1;
    localparam logic [ADDR_WIDTH:0] NREGS_EXT = (ADDR_WIDTH+1)'(NREGS);
    localparam logic [3:0]          WS_LAST   = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_TERM} state_t;

    state_t                  state, state_nxt;
    logic [3:0]              wait_cnt, wait_cnt_nxt;
    logic [ADDR_WIDTH-1:0]   adr_q;
    logic                    wr_q;
    logic [DATA_WIDTH-1:0]   dat_q;
    logic [DATA_WIDTH-1:0]   regs [NREGS];

    logic                    req, busy, latch, enter_term;
    logic [ADDR_WIDTH-1:0]   adr_dec;
    logic                    wr_dec, mapped;
    logic [IDX_W-1:0]        idx_dec;
    logic                    ack_nxt, err_nxt, rty_nxt;
    logic [DATA_WIDTH-1:0]   dat_nxt;

`ifdef WB_SCRATCH_RETRY_EN
    assign busy = busy_i;
`else
    assign busy = 1'b0;
`endif

    assign req = cyc_i & stb_i;

    // Decode the live bus in IDLE (the sampling cycle) and the latched copy afterwards.
    assign adr_dec = (state == ST_IDLE) ? adr_i : adr_q;
    assign wr_dec  = (state == ST_IDLE) ? wr_i  : wr_q;
    assign mapped  = ({1'b0, adr_dec} < NREGS_EXT);
    assign idx_dec = adr_dec[IDX_W-1:0];

    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        latch        = 1'b0;
        enter_term   = 1'b0;
        ack_nxt      = 1'b0;
        err_nxt      = 1'b0;
        rty_nxt      = 1'b0;
        dat_nxt      = FILL_VALUE;
        case (state)
            ST_IDLE: begin
                if (req) begin
                    latch        = 1'b1;
                    wait_cnt_nxt = 4'd0;
                    if (WAIT_STATES > 0) state_nxt  = ST_WAIT;
                    else                 enter_term = 1'b1;
                end
            end
            ST_WAIT: begin
                if (!req)                       state_nxt    = ST_IDLE;
                else if (wait_cnt == WS_LAST)   enter_term   = 1'b1;
                else                            wait_cnt_nxt = wait_cnt + 4'd1;
            end
            ST_TERM: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
        if (enter_term) begin
            state_nxt = ST_TERM;
            if (busy) begin
                rty_nxt = 1'b1;
            end else if (!mapped && ERR_ON_UNMAPPED) begin
                err_nxt = 1'b1;
            end else begin
                ack_nxt = 1'b1;
                if (!wr_dec && mapped) dat_nxt = regs[idx_dec];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= ST_IDLE;
            wait_cnt <= 4'd0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            adr_q <= '0;
            wr_q  <= 1'b0;
            dat_q <= '0;
            ack_o <= 1'b0;
            err_o <= 1'b0;
            rty_o <= 1'b0;
            dat_o <= FILL_VALUE;
            for (int k = 0; k < NREGS; k++) regs[k] <= '0;
        end else begin
            ack_o <= ack_nxt;
            err_o <= err_nxt;
            rty_o <= rty_nxt;
            dat_o <= dat_nxt;
            if (latch) begin
                adr_q <= adr_i;
                wr_q  <= wr_i;
                dat_q <= dat_i;
            end
            // Commit only on the edge closing an acked write to a mapped register.
            if (state == ST_TERM && ack_o && wr_q && mapped) regs[idx_dec] <= dat_q;
        end
    end

    for (genvar k = 0; k < NREGS; k++) begin : g_flat
        assign regs_o[k*DATA_WIDTH +: DATA_WIDTH] = regs[k];
    end

endmodule

// File: tb/tb_wishbone_scratch_slave.sv
// Directed bench: three instances (WS=0/err, WS=3/err, WS=0/ack-unmapped) driven from one sequence.
module tb_wishbone_scratch_slave;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst   [3];
    logic         cyc   [3];
    logic         stb   [3];
    logic         wr    [3];
    logic [15:0]  adr   [3];
    logic [7:0]   dat_w [3];
    logic [7:0]   dat_r [3];
    logic         ack   [3];
    logic         err   [3];
    logic         rty   [3];
    logic [127:0] regs  [3];
`ifdef WB_SCRATCH_RETRY_EN
    logic         busy  [3];
`endif

    wishbone_scratch_slave #(.WAIT_STATES(0), .ERR_ON_UNMAPPED(1'b1)) dut0 (
        .clk_i(clk), .rst_i(rst[0]), .cyc_i(cyc[0]), .stb_i(stb[0]), .wr_i(wr[0]),
        .adr_i(adr[0]), .dat_i(dat_w[0]), .dat_o(dat_r[0]), .ack_o(ack[0]),
        .err_o(err[0]), .rty_o(rty[0]),
`ifdef WB_SCRATCH_RETRY_EN
        .busy_i(busy[0]),
`endif
        .regs_o(regs[0]));

    wishbone_scratch_slave #(.WAIT_STATES(3), .ERR_ON_UNMAPPED(1'b1)) dut1 (
        .clk_i(clk), .rst_i(rst[1]), .cyc_i(cyc[1]), .stb_i(stb[1]), .wr_i(wr[1]),
        .adr_i(adr[1]), .dat_i(dat_w[1]), .dat_o(dat_r[1]), .ack_o(ack[1]),
        .err_o(err[1]), .rty_o(rty[1]),
`ifdef WB_SCRATCH_RETRY_EN
        .busy_i(busy[1]),
`endif
        .regs_o(regs[1]));

    wishbone_scratch_slave #(.WAIT_STATES(0), .ERR_ON_UNMAPPED(1'b0)) dut2 (
        .clk_i(clk), .rst_i(rst[2]), .cyc_i(cyc[2]), .stb_i(stb[2]), .wr_i(wr[2]),
        .adr_i(adr[2]), .dat_i(dat_w[2]), .dat_o(dat_r[2]), .ack_o(ack[2]),
        .err_o(err[2]), .rty_o(rty[2]),
`ifdef WB_SCRATCH_RETRY_EN
        .busy_i(busy[2]),
`endif
        .regs_o(regs[2]));

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One transfer; lat stays 0 if no termination appears within the budget.
    task automatic xfer(input int d, input logic w, input logic [15:0] a, input logic [7:0] wd,
                        output int lat, output logic t_ack, output logic t_err,
                        output logic t_rty, output logic [7:0] rd);
        @(negedge clk);
        cyc[d] = 1'b1; stb[d] = 1'b1; wr[d] = w; adr[d] = a; dat_w[d] = wd;
        lat = 0; t_ack = 1'b0; t_err = 1'b0; t_rty = 1'b0; rd = 8'h00;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (ack[d] | err[d] | rty[d]) begin
                lat = i; t_ack = ack[d]; t_err = err[d]; t_rty = rty[d]; rd = dat_r[d];
                break;
            end
        end
        cyc[d] = 1'b0; stb[d] = 1'b0; wr[d] = 1'b0; dat_w[d] = 8'h00;
    endtask

    // Cycle after a termination: strobes must be gone and dat_o back to fill.
    task automatic post_chk(input int d, input string tag);
        @(negedge clk);
        chk({tag, "_pulse"}, {ack[d], err[d], rty[d]}, 3'b000);
        chk({tag, "_idle_dat"}, dat_r[d], 8'hFF);
    endtask

    int          lat;
    logic        t_ack, t_err, t_rty;
    logic [7:0]  rd;
    logic [3:0]  pat;
    logic        seen;
    logic [127:0] exp0;

    initial begin
        for (int d = 0; d < 3; d++) begin
            rst[d] = 1'b1; cyc[d] = 1'b0; stb[d] = 1'b0; wr[d] = 1'b0;
            adr[d] = 16'h0; dat_w[d] = 8'h00;
`ifdef WB_SCRATCH_RETRY_EN
            busy[d] = 1'b0;
`endif
        end
        exp0 = '0;
        repeat (3) @(negedge clk);
        for (int d = 0; d < 3; d++) rst[d] = 1'b0;
        @(negedge clk);
        chk("rst_dat", dat_r[0], 8'hFF);
        chk("rst_term", {ack[0], err[0], rty[0]}, 3'b000);
        chk("rst_regs", regs[0], 128'h0);

        xfer(0, 1'b0, 16'd3, 8'h00, lat, t_ack, t_err, t_rty, rd);
        chk("rd3_lat", lat, 1);
        chk("rd3_ack", {t_ack, t_err}, 2'b10);
        chk("rd3_dat", rd, 8'h00);
        post_chk(0, "rd3");

        xfer(0, 1'b1, 16'd5, 8'hA5, lat, t_ack, t_err, t_rty, rd);
        chk("wr5_lat", lat, 1);
        chk("wr5_ack", t_ack, 1'b1);
        post_chk(0, "wr5");
        exp0[47:40] = 8'hA5;
        chk("wr5_regs", regs[0], exp0);
        xfer(0, 1'b0, 16'd5, 8'h00, lat, t_ack, t_err, t_rty, rd);
        chk("rd5_ack", t_ack, 1'b1);
        chk("rd5_dat", rd, 8'hA5);

        // Request held through TERM is re-sampled in the following IDLE cycle.
        @(negedge clk);
        cyc[0] = 1'b1; stb[0] = 1'b1; wr[0] = 1'b0; adr[0] = 16'd5;
        pat = 4'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            pat = {pat[2:0], ack[0]};
        end
        cyc[0] = 1'b0; stb[0] = 1'b0;
        chk("b2b_ack_pattern", pat, 4'b1010);
        @(negedge clk);

        xfer(0, 1'b1, 16'h0010, 8'h11, lat, t_ack, t_err, t_rty, rd);
        chk("unm_lat", lat, 1);
        chk("unm_err", {t_ack, t_err}, 2'b01);
        chk("unm_dat", rd, 8'hFF);
        post_chk(0, "unm");
        chk("unm_regs", regs[0], exp0);
        xfer(0, 1'b0, 16'h8005, 8'h00, lat, t_ack, t_err, t_rty, rd);
        chk("alias_err", {t_ack, t_err}, 2'b01);

        xfer(2, 1'b1, 16'h0010, 8'h22, lat, t_ack, t_err, t_rty, rd);
        chk("unm0_wr_ack", {t_ack, t_err}, 2'b10);
        post_chk(2, "unm0");
        chk("unm0_regs", regs[2], 128'h0);
        xfer(2, 1'b0, 16'h0010, 8'h00, lat, t_ack, t_err, t_rty, rd);
        chk("unm0_rd_ack", t_ack, 1'b1);
        chk("unm0_rd_dat", rd, 8'hFF);
        xfer(2, 1'b0, 16'h000F, 8'h00, lat, t_ack, t_err, t_rty, rd);
        chk("last_reg_rd", {t_ack, rd}, {1'b1, 8'h00});

        xfer(1, 1'b0, 16'd0, 8'h00, lat, t_ack, t_err, t_rty, rd);
        chk("ws3_rd_lat", lat, 4);
        chk("ws3_rd_ack", t_ack, 1'b1);
        xfer(1, 1'b1, 16'd7, 8'h5A, lat, t_ack, t_err, t_rty, rd);
        chk("ws3_wr_lat", lat, 4);
        @(negedge clk);
        chk("ws3_wr_reg7", regs[1][63:56], 8'h5A);

        @(negedge clk);
        cyc[1] = 1'b1; stb[1] = 1'b1; wr[1] = 1'b1; adr[1] = 16'd9; dat_w[1] = 8'hC3;
        seen = 1'b0;
        repeat (2) begin
            @(negedge clk);
            seen = seen | ack[1] | err[1] | rty[1];
        end
        stb[1] = 1'b0;
        repeat (6) begin
            @(negedge clk);
            seen = seen | ack[1] | err[1] | rty[1];
        end
        cyc[1] = 1'b0; wr[1] = 1'b0;
        chk("abort_no_term", seen, 1'b0);
        chk("abort_reg9", regs[1][79:72], 8'h00);

        @(negedge clk);
        cyc[1] = 1'b1; stb[1] = 1'b1; wr[1] = 1'b1; adr[1] = 16'd1; dat_w[1] = 8'h3C;
        seen = 1'b0;
        repeat (2) begin
            @(negedge clk);
            seen = seen | ack[1] | err[1] | rty[1];
        end
        rst[1] = 1'b1;
        @(negedge clk);
        rst[1] = 1'b0; cyc[1] = 1'b0; stb[1] = 1'b0; wr[1] = 1'b0;
        repeat (6) begin
            @(negedge clk);
            seen = seen | ack[1] | err[1] | rty[1];
        end
        chk("rstmid_no_term", seen, 1'b0);
        chk("rstmid_reg1", regs[1][15:8], 8'h00);
        xfer(1, 1'b0, 16'd1, 8'h00, lat, t_ack, t_err, t_rty, rd);
        chk("rstmid_rd1", {t_ack, rd}, {1'b1, 8'h00});

`ifdef WB_SCRATCH_RETRY_EN
        busy[0] = 1'b1;
        xfer(0, 1'b1, 16'd2, 8'h77, lat, t_ack, t_err, t_rty, rd);
        chk("rty_term", {t_ack, t_err, t_rty}, 3'b001);
        chk("rty_dat", rd, 8'hFF);
        post_chk(0, "rty");
        chk("rty_reg2", regs[0][23:16], 8'h00);
        busy[0] = 1'b0;
        xfer(0, 1'b1, 16'd2, 8'h77, lat, t_ack, t_err, t_rty, rd);
        chk("rty_retry_ack", {t_ack, t_rty}, 2'b10);
        @(negedge clk);
        chk("rty_reg2_wr", regs[0][23:16], 8'h77);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

endmodule
